// File: rtl/zxuno_option_bank_if.sv
// ZX-Uno register-bus port bundle for zxuno_option_bank.
// Ports: zxuno_addr/zxuno_regrd/zxuno_regwr/din from the bus master; dout/oe back from the register block.
// Read data is combinational from the slave; writes are sampled on the slave's clock edge.
interface zxuno_option_bank_if;
  logic [7:0] zxuno_addr;
  logic       zxuno_regrd;
  logic       zxuno_regwr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe;

  modport master (
    output zxuno_addr, zxuno_regrd, zxuno_regwr, din,
    input  dout, oe
  );

  modport slave (
    input  zxuno_addr, zxuno_regrd, zxuno_regwr, din,
    output dout, oe
  );
endinterface

// File: rtl/zxuno_option_bank.sv
// Bank of NREGS ZX-Uno option registers; bus writes are staged in shadows and committed atomically on apply_i.
// Ports: clk, rst_n (sync, active-low), bus (zxuno_option_bank_if.slave), apply_i, options_o, pending_o, locked_o.
// Optional write-protect lock FSM at LOCK_ADDR is built only when OPTION_LOCK_EN is defined; default build has no lock.
module zxuno_option_bank #(
  parameter int unsigned          NREGS        = 2,
  parameter logic [7:0]           BASE_ADDR    = 8'h0E,
  parameter logic [7:0]           LOCK_ADDR    = 8'h0D,
  parameter logic [NREGS*8-1:0]   RESET_VALUES = 16'h0028,
  parameter logic [NREGS*8-1:0]   FORCE_SET    = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  zxuno_option_bank_if.slave   bus,
  input  logic                 apply_i,
  output logic [NREGS*8-1:0]   options_o,
  output logic                 pending_o,
  output logic                 locked_o
);

  localparam int BASE_I    = int'(BASE_ADDR);
  localparam int LAST_ADDR = BASE_I + int'(NREGS) - 1;
  localparam int LOCK_I    = int'(LOCK_ADDR);

  // Configuration sanity: bank must fit in the 8-bit space without wrap,
  // and the lock register must not alias a bank register.
  generate
    if (NREGS == 0 || NREGS > 8) begin : g_bad_nregs
      $error("zxuno_option_bank: NREGS must be 1..8");
    end
    if (LAST_ADDR > 255) begin : g_bad_range
      $error("zxuno_option_bank: bank range exceeds 8'hFF");
    end
    if (LOCK_I >= BASE_I && LOCK_I <= LAST_ADDR) begin : g_bad_lock
      $error("zxuno_option_bank: LOCK_ADDR overlaps bank range");
    end
  endgenerate

  logic [NREGS*8-1:0] shadow_q, shadow_d;
  logic [NREGS*8-1:0] active_q, active_d;
  logic               pending_q, pending_d;

  logic       bank_hit;
  logic [2:0] bank_idx;
  logic [7:0] rd_shadow;
  logic       lock_hit;
  logic       locked;
  logic       armed;
  logic       wr_en;

  // Address decode, one comparator per register.
  always_comb begin
    bank_hit  = 1'b0;
    bank_idx  = 3'd0;
    rd_shadow = 8'h00;
    for (int i = 0; i < int'(NREGS); i++) begin
      if (bus.zxuno_addr == 8'(BASE_I + i)) begin
        bank_hit  = 1'b1;
        bank_idx  = 3'(i);
        rd_shadow = shadow_q[i*8 +: 8] | FORCE_SET[i*8 +: 8];
      end
    end
  end

`ifdef OPTION_LOCK_EN
  typedef enum logic [1:0] {
    LK_UNLOCKED = 2'd0,
    LK_LOCKED   = 2'd1,
    LK_ARMED    = 2'd2
  } lock_state_e;

  lock_state_e lock_q, lock_d;

  assign lock_hit = (bus.zxuno_addr == LOCK_ADDR);

  always_ff @(posedge clk) begin
    if (!rst_n) lock_q <= LK_UNLOCKED;
    else        lock_q <= lock_d;
  end

  always_comb begin
    lock_d = lock_q;
    locked = 1'b0;
    armed  = 1'b0;
    case (lock_q)
      LK_UNLOCKED: begin
        if (bus.zxuno_regwr && lock_hit && bus.din == 8'hA5) lock_d = LK_LOCKED;
      end
      LK_LOCKED: begin
        locked = 1'b1;
        if (bus.zxuno_regwr && lock_hit && bus.din == 8'h55) lock_d = LK_ARMED;
      end
      LK_ARMED: begin
        locked = 1'b1;
        armed  = 1'b1;
        // Any write to the lock or bank other than the final key breaks the sequence.
        if (bus.zxuno_regwr && lock_hit)
          lock_d = (bus.din == 8'hAA) ? LK_UNLOCKED : LK_LOCKED;
        else if (bus.zxuno_regwr && bank_hit)
          lock_d = LK_LOCKED;
      end
      default: begin
        lock_d = LK_LOCKED;
        locked = 1'b1;
      end
    endcase
  end
`else
  assign lock_hit = 1'b0;
  assign locked   = 1'b0;
  assign armed    = 1'b0;
`endif

  // Lock state is the pre-edge value, so a bank write alongside the locking
  // write still lands.
  assign wr_en = bus.zxuno_regwr && bank_hit && !locked;

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    for (int i = 0; i < int'(NREGS); i++) begin
      if (wr_en && bank_idx == 3'(i)) shadow_d[i*8 +: 8] = bus.din;
    end
    // A same-cycle write is folded into the commit via shadow_d.
    if (apply_i && (pending_q || wr_en)) begin
      active_d  = shadow_d;
      pending_d = 1'b0;
    end else if (wr_en) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q  <= RESET_VALUES;
      active_q  <= RESET_VALUES;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  // Combinational readback.
  always_comb begin
    bus.oe   = 1'b0;
    bus.dout = 8'hFF;
    if (bus.zxuno_regrd && bank_hit) begin
      bus.oe   = 1'b1;
      bus.dout = rd_shadow;
    end else if (bus.zxuno_regrd && lock_hit) begin
      bus.oe   = 1'b1;
      bus.dout = {5'b00000, pending_q, armed, locked};
    end
  end

  assign options_o = active_q | FORCE_SET;
  assign pending_o = pending_q;
  assign locked_o  = locked;

endmodule

// File: tb/tb_zxuno_option_bank.sv
// Self-checking bench for zxuno_option_bank: two instances (plain and with a forced bit) on identical stimulus.
// Ports: all DUT ports driven from bench variables through two interface instances.
// Directed sequence first, then randomized traffic compared every cycle against a behavioural model.
module tb_zxuno_option_bank;
  localparam int         NREGS = 2;
  localparam logic [7:0] BASE  = 8'h0E;
  localparam logic [7:0] LOCKA = 8'h0D;
  localparam logic [15:0] RSTV = 16'h0028;
  localparam logic [15:0] FS1  = 16'h0002;

  logic clk;
  logic rst_n;
  logic [7:0] addr, din;
  logic rd, wr, apply;
  logic [15:0] opt0, opt1;
  logic pend0, pend1, lck0, lck1;

  zxuno_option_bank_if bus0();
  zxuno_option_bank_if bus1();

  assign bus0.zxuno_addr  = addr;
  assign bus0.zxuno_regrd = rd;
  assign bus0.zxuno_regwr = wr;
  assign bus0.din         = din;
  assign bus1.zxuno_addr  = addr;
  assign bus1.zxuno_regrd = rd;
  assign bus1.zxuno_regwr = wr;
  assign bus1.din         = din;

  zxuno_option_bank #(.NREGS(NREGS), .BASE_ADDR(BASE), .LOCK_ADDR(LOCKA),
                      .RESET_VALUES(RSTV), .FORCE_SET(16'h0000)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .apply_i(apply),
    .options_o(opt0), .pending_o(pend0), .locked_o(lck0));

  zxuno_option_bank #(.NREGS(NREGS), .BASE_ADDR(BASE), .LOCK_ADDR(LOCKA),
                      .RESET_VALUES(RSTV), .FORCE_SET(FS1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .apply_i(apply),
    .options_o(opt1), .pending_o(pend1), .locked_o(lck1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: register contents as byte arrays, lock as two flags.
  logic [7:0] m_shadow [NREGS];
  logic [7:0] m_active [NREGS];
  logic       m_pending;
  logic       m_locked;
  logic       m_armed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bank_index(input logic [7:0] a);
    int d;
    d = int'(a) - int'(BASE);
    if (d >= 0 && d < NREGS) return d;
    return -1;
  endfunction

  function automatic logic [15:0] exp_options(input logic [15:0] fs);
    logic [15:0] v;
    for (int i = 0; i < NREGS; i++) v[i*8 +: 8] = m_active[i];
    return v | fs;
  endfunction

  function automatic logic [8:0] exp_read(input logic [15:0] fs);
    int k;
    k = bank_index(addr);
    if (rd && k >= 0) return {1'b1, m_shadow[k] | fs[k*8 +: 8]};
`ifdef OPTION_LOCK_EN
    if (rd && addr == LOCKA) return {1'b1, 5'b00000, m_pending, m_armed, m_locked};
`endif
    return {1'b0, 8'hFF};
  endfunction

  task automatic model_update();
    int k;
    logic was_locked, wrote;
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        m_shadow[i] = RSTV[i*8 +: 8];
        m_active[i] = RSTV[i*8 +: 8];
      end
      m_pending = 1'b0;
      m_locked  = 1'b0;
      m_armed   = 1'b0;
      return;
    end
    was_locked = m_locked;
    k = bank_index(addr);
    wrote = wr && (k >= 0) && !was_locked;
    if (wrote) m_shadow[k] = din;
    if (apply && (m_pending || wrote)) begin
      for (int i = 0; i < NREGS; i++) m_active[i] = m_shadow[i];
      m_pending = 1'b0;
    end else if (wrote) begin
      m_pending = 1'b1;
    end
`ifdef OPTION_LOCK_EN
    if (wr && addr == LOCKA) begin
      if (!m_locked) begin
        if (din == 8'hA5) m_locked = 1'b1;
      end else if (!m_armed) begin
        if (din == 8'h55) m_armed = 1'b1;
      end else begin
        m_armed = 1'b0;
        if (din == 8'hAA) m_locked = 1'b0;
      end
    end else if (wr && k >= 0 && m_armed) begin
      m_armed = 1'b0;
    end
`endif
  endtask

  // The single compare process, invoked once per cycle on the falling edge.
  task automatic compare();
    logic [8:0] r0, r1;
    r0 = exp_read(16'h0000);
    r1 = exp_read(FS1);
    chk("options0", opt0, exp_options(16'h0000));
    chk("options1", opt1, exp_options(FS1));
    chk("pending0", pend0, m_pending);
    chk("pending1", pend1, m_pending);
    chk("locked0", lck0, m_locked);
    chk("locked1", lck1, m_locked);
    chk("rd0", {bus0.oe, bus0.dout}, r0);
    chk("rd1", {bus1.oe, bus1.dout}, r1);
  endtask

  task automatic drive(input logic r, input logic rdv, input logic wrv,
                       input logic [7:0] a, input logic [7:0] d, input logic ap);
    rst_n = r; rd = rdv; wr = wrv; addr = a; din = d; apply = ap;
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    model_update();
    #1;
    cycle();

    // Reset state.
    drive(1'b1, 1'b1, 1'b0, 8'h0E, 8'h00, 1'b0);
    chk("lit_rst_opt0", opt0, 16'h0028);
    chk("lit_rst_opt1", opt1, 16'h002A);
    chk("lit_rd0E", {bus0.oe, bus0.dout}, {1'b1, 8'h28});
    chk("lit_rst_lock", lck0, 1'b0);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    chk("lit_rd10", {bus0.oe, bus0.dout}, {1'b0, 8'hFF});
    cycle();

    // Staged write, readback, commit.
    drive(1'b1, 1'b0, 1'b1, 8'h0F, 8'h3C, 1'b0); cycle();
    drive(1'b1, 1'b1, 1'b0, 8'h0F, 8'h00, 1'b0);
    chk("lit_rb0F", bus0.dout, 8'h3C);
    chk("lit_pend", pend0, 1'b1);
    chk("lit_opt_stable", opt0, 16'h0028);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1); cycle();
    chk("lit_apply_opt", opt0, 16'h3C28);
    chk("lit_apply_pend", pend0, 1'b0);

    // Write with apply in the same cycle, then apply with nothing pending.
    drive(1'b1, 1'b0, 1'b1, 8'h0E, 8'h55, 1'b1); cycle();
    chk("lit_wa_opt", opt0, 16'h3C55);
    chk("lit_wa_pend", pend0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1); cycle();
    chk("lit_idle_apply", opt0, 16'h3C55);

    // Forced bit.
    drive(1'b1, 1'b0, 1'b1, 8'h0E, 8'h00, 1'b0); cycle();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1); cycle();
    drive(1'b1, 1'b1, 1'b0, 8'h0E, 8'h00, 1'b0);
    chk("lit_force_opt", opt1, 16'h3C02);
    chk("lit_force_rd", bus1.dout, 8'h02);
    cycle();

`ifdef OPTION_LOCK_EN
    drive(1'b1, 1'b0, 1'b1, LOCKA, 8'hA5, 1'b0); cycle();
    drive(1'b1, 1'b0, 1'b1, 8'h0E, 8'hFF, 1'b0); cycle();
    drive(1'b1, 1'b1, 1'b0, 8'h0E, 8'h00, 1'b0);
    chk("lit_lock_rb", bus0.dout, 8'h00);
    cycle();
    drive(1'b1, 1'b1, 1'b0, LOCKA, 8'h00, 1'b0);
    chk("lit_lock_st", {bus0.oe, bus0.dout}, {1'b1, 8'h01});
    cycle();
    drive(1'b1, 1'b0, 1'b1, LOCKA, 8'h55, 1'b0); cycle();
    drive(1'b1, 1'b1, 1'b0, LOCKA, 8'h00, 1'b0);
    chk("lit_armed_st", bus0.dout, 8'h03);
    cycle();
    drive(1'b1, 1'b0, 1'b1, LOCKA, 8'hAA, 1'b0); cycle();
    drive(1'b1, 1'b1, 1'b0, LOCKA, 8'h00, 1'b0);
    chk("lit_unlock_st", bus0.dout, 8'h00);
    cycle();
    drive(1'b1, 1'b0, 1'b1, LOCKA, 8'hA5, 1'b0); cycle();
    drive(1'b1, 1'b0, 1'b1, LOCKA, 8'h55, 1'b0); cycle();
    drive(1'b1, 1'b0, 1'b1, 8'h0E, 8'h11, 1'b0); cycle();
    drive(1'b1, 1'b0, 1'b1, LOCKA, 8'hAA, 1'b0); cycle();
    drive(1'b1, 1'b1, 1'b0, LOCKA, 8'h00, 1'b0);
    chk("lit_broken_seq", bus0.dout, 8'h01);
    cycle();
    drive(1'b1, 1'b0, 1'b1, LOCKA, 8'h55, 1'b0); cycle();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0); cycle();
    drive(1'b1, 1'b1, 1'b0, LOCKA, 8'h00, 1'b0);
    chk("lit_rst_unlock", bus0.dout, 8'h00);
    chk("lit_rst_opt", opt0, 16'h0028);
    cycle();
`else
    drive(1'b1, 1'b1, 1'b0, LOCKA, 8'h00, 1'b0);
    chk("lit_nolock_rd", {bus0.oe, bus0.dout}, {1'b0, 8'hFF});
    cycle();
    drive(1'b1, 1'b0, 1'b1, LOCKA, 8'hA5, 1'b0); cycle();
    drive(1'b1, 1'b0, 1'b1, 8'h0E, 8'h77, 1'b0); cycle();
    drive(1'b1, 1'b1, 1'b0, 8'h0E, 8'h00, 1'b0);
    chk("lit_nolock_wr", bus0.dout, 8'h77);
    chk("lit_nolock_lck", lck0, 1'b0);
    cycle();
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] a, d;
      case ($urandom_range(0, 5))
        0: a = LOCKA;
        1, 2: a = BASE;
        3: a = BASE + 8'd1;
        4: a = BASE + 8'd2;
        default: a = 8'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: d = 8'hA5;
        1: d = 8'h55;
        2: d = 8'hAA;
        default: d = 8'($urandom);
      endcase
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 9) < 4), a, d, ($urandom_range(0, 6) == 0));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/zxuno_option_bank.md
# zxuno_option_bank

Parametrised bank of ZX-Uno device-option registers, the generalised successor to the fixed two-register enable-options block. Holds NREGS consecutive 8-bit option registers at a configurable base address, each with its own reset value and per-bit forced-disable mask. Writes are staged in shadow registers and committed atomically to the live outputs on an external apply strobe, normally the frame/vsync pulse, so peripherals never see half-updated option sets. An optional lock state machine protects the bank against stray writes. Sits on the ZX-Uno register bus beside the other zxuno_addr-decoded peripherals.

## Interface
- NREGS, 2, number of option registers (1..8)
- BASE_ADDR, 8'h0E, ZX-Uno address of register 0; register i is at BASE_ADDR+i
- LOCK_ADDR, 8'h0D, ZX-Uno address of lock/status register; must lie outside the bank range
- RESET_VALUES, {NREGS*8}, default 16'h0028; byte i is the reset value of register i
- FORCE_SET, {NREGS*8}, default 0; bit set = that option bit always reads and drives 1 (feature not built)
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- zxuno_addr  in  8  selected ZX-Uno register address
- zxuno_regrd  in  1  read qualifier
- zxuno_regwr  in  1  write qualifier; every cycle high counts as one write
- din  in  8  write data
- apply  in  1  commit strobe, one cycle
- dout  out  8  read data, combinational
- oe  out  1  read data valid, combinational
- options  out  NREGS*8  live option bits, registered
- pending  out  1  shadow differs from live (uncommitted write present)
- locked  out  1  bank write-protected

## Operation
- Decode: register i is selected when zxuno_addr == BASE_ADDR+i with 8-bit arithmetic. BASE_ADDR+NREGS-1 > 8'hFF is an elaboration error; no wrap.
- Write: regwr, register i selected, not locked: shadow[i] <= din; pending <= 1.
- Commit: apply=1 and pending=1: active <= shadow; pending <= 0. A write in the same cycle is included in the commit, so the new value goes live and pending ends at 0. apply with pending=0 does nothing.
- options = active | FORCE_SET.
- Read of register i: oe=1, dout = shadow[i] | FORCE_SET byte i. Software sees the staged value.
- Read of LOCK_ADDR: oe=1, dout = {5'b0, pending, armed, locked}.
- Any other read, or no read: oe=0, dout=8'hFF.
- Lock FSM states:
  - UNLOCKED: a write of 8'hA5 to LOCK_ADDR goes to LOCKED.
  - LOCKED: a write of 8'h55 to LOCK_ADDR goes to ARMED. Other writes are ignored.
  - ARMED: a write of 8'hAA to LOCK_ADDR goes to UNLOCKED. Any other write to LOCK_ADDR or to a bank register goes back to LOCKED.
  - Bus writes elsewhere do not affect the FSM.
- locked = 1 in LOCKED and ARMED. armed = 1 in ARMED.
- Bank writes while locked are discarded and pending is unchanged.
- apply still commits while locked, so writes staged before locking still go live.

## Timing
- Reset (rst_n=0 at clk edge): shadow = active = RESET_VALUES, pending=0, FSM=UNLOCKED. Outputs: options = RESET_VALUES | FORCE_SET, locked=0, oe=0, dout=8'hFF.
- Reset has priority over write and apply in the same cycle. Reset mid-sequence returns to UNLOCKED and drops uncommitted writes.
- Write to readback: one cycle; dout shows new shadow the cycle after the write edge.
- apply to options: options change on the clk edge where apply=1 is sampled; pending falls on the same edge.
- FSM transitions take effect on the write edge. A bank write in the same cycle as the locking write is still accepted, because lock state is sampled before the edge.

## Configuration
- OPTION_LOCK_EN defined: lock FSM and LOCK_ADDR decode are built as described above.
- OPTION_LOCK_EN undefined:
  - No FSM is built; locked=0 permanently.
  - LOCK_ADDR is not decoded: reads give oe=0, writes are ignored.
  - Bank writes are always accepted.
  - pending is visible only on the port.

## Test plan
- Reset with defaults: options=16'h0028, read 8'h0E -> oe=1, dout=8'h28; read 8'h10 -> oe=0, dout=8'hFF.
- Write 8'h0F=8'h3C, then read 8'h0F: dout=8'h3C, options unchanged, pending=1. Pulse apply: options[15:8]=8'h3C next cycle, pending=0.
- Write and apply in the same cycle: the value is live after that edge and pending=0. apply with no pending write leaves options stable.
- FORCE_SET=16'h0002: write 8'h0E=8'h00 then apply -> options[1]=1 and readback dout=8'h02.
- Lock (OPTION_LOCK_EN): write 8'hA5 to 8'h0D, then write 8'h0E=8'hFF -> shadow unchanged, status read = 8'h01.
- Unlock sequence: 55, AA unlocks. 55, then a bank write, then AA stays locked. Assert rst_n mid-sequence -> UNLOCKED and RESET_VALUES restored.
